// File: rtl/walk_phase_server.sv
// Pedestrian walk-phase sequencer: stop traffic, wait for clearance, WALK, flashing DON'T WALK,
// then a recovery gap. Optional Chirp output is enabled by defining WALK_CHIRP_EN.
module walk_phase_server #(
    parameter int unsigned WALK_TICKS  = 7,
    parameter int unsigned FLASH_TICKS = 5,
    parameter int unsigned GAP_TICKS   = 10,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1hz,
    input  logic WR,
    input  logic Veh_Clear,
    output logic Walk_Stop_Req,
    output logic Walk_Lamp,
    output logic DontWalk_Lamp,
    output logic WR_Reset,
    output logic Busy
`ifdef WALK_CHIRP_EN
    ,
    output logic Chirp
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitClear,
        StWalk,
        StFlash,
        StGap
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             walk_q, walk_d;
    logic             dw_q, dw_d;
    logic             wrr_q, wrr_d;
    logic             busy_q, busy_d;

    // Next state and tick counter; timed states leave on the tick that finds the counter at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (WR) state_d = StWaitClear;
            end
            StWaitClear: begin
                if (Veh_Clear) begin
                    state_d = StWalk;
                    cnt_d   = CNT_W'(WALK_TICKS);
                end
            end
            StWalk: begin
                if (tick_1hz) begin
                    if (cnt_q == CntOne) begin
                        state_d = StFlash;
                        cnt_d   = CNT_W'(FLASH_TICKS);
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            StFlash: begin
                if (tick_1hz) begin
                    if (cnt_q == CntOne) begin
                        state_d = StGap;
                        cnt_d   = CNT_W'(GAP_TICKS);
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            StGap: begin
                if (tick_1hz) begin
                    if (cnt_q == CntOne) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        stop_d = (state_d == StWaitClear) || (state_d == StWalk) || (state_d == StFlash);
        walk_d = (state_d == StWalk);
        busy_d = (state_d != StIdle);
        wrr_d  = (state_q == StWaitClear) && (state_d == StWalk);
        dw_d   = 1'b1;
        if (state_d == StWalk) begin
            dw_d = 1'b0;
        end else if ((state_d == StFlash) && (state_q == StFlash)) begin
            dw_d = tick_1hz ? ~dw_q : dw_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            wrr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            walk_q  <= walk_d;
            dw_q    <= dw_d;
            wrr_q   <= wrr_d;
            busy_q  <= busy_d;
        end
    end

    assign Walk_Stop_Req = stop_q;
    assign Walk_Lamp     = walk_q;
    assign DontWalk_Lamp = dw_q;
    assign WR_Reset      = wrr_q;
    assign Busy          = busy_q;

`ifdef WALK_CHIRP_EN
    logic chirp_q, chirp_d;

    // In FLASH, chirp on alternate ticks: those that find the lamp lit (ticks 1, 3, 5, ...).
    always_comb begin
        chirp_d = tick_1hz && ((state_q == StWalk) || ((state_q == StFlash) && dw_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chirp_q <= 1'b0;
        end else begin
            chirp_q <= chirp_d;
        end
    end

    assign Chirp = chirp_q;
`endif

endmodule
